// File: rtl/sync_ram_ctrl.sv
// Synchronous single-port RAM with a valid/ready request port, a fixed-latency response
// pipeline (1 or 2 cycles), selectable read-during-write behaviour and a zeroing sweep.
module sync_ram_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic [1:0]            debug
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // responses have no backpressure and appear exactly READ_LATENCY cycles later.
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];
  logic                    accept;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rsp_word;
  logic                    last_valid;
  logic [DATA_WIDTH-1:0]   last_data;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [1:0]              debug_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == '1) begin
          state_d     = ST_RUN;
          clear_ptr_d = '0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign busy      = (state_q == ST_CLEAR);
  assign req_ready = (state_q == ST_RUN) && !clear;
  assign accept    = req_valid && req_ready;

  // The sweep owns the write port while busy; requests cannot be accepted then.
  assign mem_we    = busy || (accept && we);
  assign mem_addr  = busy ? clear_ptr_q : address;
  assign mem_wdata = busy ? '0 : data_in;
  assign rsp_word  = (we && (WRITE_MODE != 0)) ? data_in : mem_q[address];

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= accept;
        if (accept) s1_data_q <= rsp_word;
      end
    end
    assign last_valid = s1_valid_q;
    assign last_data  = s1_data_q;
  end else begin : g_lat1
    assign last_valid = accept;
    assign last_data  = rsp_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      data_out_q  <= '0;
      debug_q     <= 2'b00;
    end else begin
      rsp_valid_q <= last_valid;
      if (last_valid) data_out_q <= last_data;
      if (accept) debug_q <= we ? 2'b01 : 2'b10;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign data_out  = data_out_q;
  assign debug     = debug_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl: three configurations (default, write-first/latency 2,
// no clear on reset), directed sequences, a vector table and a random run against a model.
module tb_sync_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 8;
  localparam int ND = 3;

  function automatic int lat_f(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int wm_f(input int k);  return (k == 0) ? 0 : 1; endfunction
  function automatic int cor_f(input int k); return (k == 2) ? 0 : 1; endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          rv     [ND];
  logic          we_s   [ND];
  logic          clr    [ND];
  logic          rdy    [ND];
  logic          rspv   [ND];
  logic          busy_s [ND];
  logic [AW-1:0] addr   [ND];
  logic [DW-1:0] din    [ND];
  logic [DW-1:0] dout   [ND];
  logic [1:0]    dbg    [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int WM  = (g == 0) ? 0 : 1;
    localparam int COR = (g == 2) ? 0 : 1;
    sync_ram_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
      .WRITE_MODE(WM), .CLEAR_ON_RESET(COR)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(rv[g]), .req_ready(rdy[g]), .we(we_s[g]),
      .address(addr[g]), .data_in(din[g]), .clear(clr[g]),
      .rsp_valid(rspv[g]), .data_out(dout[g]), .busy(busy_s[g]), .debug(dbg[g])
    );
  end

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;
  int rsp2_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // scoreboard / reference model: memory image, sweep countdown, expected response queue
  logic [DW-1:0] mem_m [N];
  int            sweep_m = 0;
  logic [DW-1:0] exp_q [$];
  int            due_q [$];
  logic [DW-1:0] last_m = '0;
  logic [1:0]    dbg_m  = 2'b00;

  always @(negedge clk) begin : monitor
    int k;
    logic acc;
    logic [DW-1:0] w;
    k = cur;
    if (rst) begin
      chk("rst_rsp_valid", 32'(rspv[k]), 32'd0);
      chk("rst_data_out", 32'(dout[k]), 32'd0);
      chk("rst_debug", 32'(dbg[k]), 32'd0);
      chk("rst_busy", 32'(busy_s[k]), 32'(cor_f(k)));
      chk("rst_req_ready", 32'(rdy[k]), 32'(cor_f(k) == 0));
      sweep_m = (cor_f(k) != 0) ? N : 0;
      exp_q.delete();
      due_q.delete();
      last_m = '0;
      dbg_m  = 2'b00;
      if (cor_f(k) != 0) for (int i = 0; i < N; i++) mem_m[i] = '0;
    end else begin
      chk("busy", 32'(busy_s[k]), 32'(sweep_m > 0));
      chk("req_ready", 32'(rdy[k]), 32'(sweep_m == 0 && !clr[k]));
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        chk("rsp_valid", 32'(rspv[k]), 32'd1);
        chk("rsp_data", 32'(dout[k]), 32'(exp_q[0]));
        last_m = exp_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        chk("rsp_idle", 32'(rspv[k]), 32'd0);
        chk("data_hold", 32'(dout[k]), 32'(last_m));
      end
      chk("debug", 32'(dbg[k]), 32'(dbg_m));
      acc = rv[k] && (sweep_m == 0) && !clr[k];
      if (acc) begin
        w = (we_s[k] && wm_f(k) != 0) ? din[k] : mem_m[addr[k]];
        exp_q.push_back(w);
        due_q.push_back(cyc + lat_f(k));
        if (we_s[k]) mem_m[addr[k]] = din[k];
        dbg_m = we_s[k] ? 2'b01 : 2'b10;
      end
      if (sweep_m > 0) sweep_m--;
      else if (clr[k]) begin
        sweep_m = N;
        for (int i = 0; i < N; i++) mem_m[i] = '0;
      end
    end
  end

  always @(negedge clk) if (!rst && rspv[2]) rsp2_cnt++;

  // driver tasks: all inputs change 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    cur = k;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
  endtask

  task automatic req(input int k, input logic w, input int a, input int d);
    rv[k] = 1'b1; we_s[k] = w; addr[k] = AW'(a); din[k] = DW'(d);
    step();
    rv[k] = 1'b0; we_s[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    for (int i = 0; i < 40 && !rdy[k]; i++) step();
    chk("ready_wait", 32'(rdy[k]), 32'd1);
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_s[k]) break;
      n++;
    end
    step();
  endtask

  task automatic random_run(input int k, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rv[k]   = ($urandom_range(0, 3) != 0);
      we_s[k] = 1'($urandom_range(0, 1));
      addr[k] = AW'($urandom_range(0, N - 1));
      din[k]  = DW'($urandom_range(0, 255));
      clr[k]  = ($urandom_range(0, 40) == 0);
      step();
    end
    rv[k] = 1'b0; we_s[k] = 1'b0; clr[k] = 1'b0;
    repeat (4) step();
  endtask

  typedef struct {
    logic       w;
    int         a;
    int         d;
    int         exp_d;
    logic [1:0] exp_dbg;
  } vec_t;

  vec_t vt [9];
  int   n;
  int   base;

  initial begin
    vt[0] = '{1'b1, 3, 'hA5, 'h00, 2'b01};
    vt[1] = '{1'b0, 3, 'h00, 'hA5, 2'b10};
    vt[2] = '{1'b1, 3, 'h5A, 'hA5, 2'b01};
    vt[3] = '{1'b0, 3, 'h00, 'h5A, 2'b10};
    vt[4] = '{1'b1, 0, 'h11, 'h00, 2'b01};
    vt[5] = '{1'b0, 0, 'h00, 'h11, 2'b10};
    vt[6] = '{1'b0, 7, 'h00, 'h00, 2'b10};
    vt[7] = '{1'b1, 7, 'hFF, 'h00, 2'b01};
    vt[8] = '{1'b0, 7, 'h00, 'hFF, 2'b10};
    for (int k = 0; k < ND; k++) begin
      rv[k] = 1'b0; we_s[k] = 1'b0; clr[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end
    rst = 1'b0;
    #2;

    // 1: sweep after reset, then every word reads zero one cycle after acceptance
    do_reset(0);
    count_busy(0, n);
    chk("t1_sweep_len", 32'(n), 32'd8);
    for (int i = 0; i < N; i++) begin
      req(0, 1'b0, i, 0);
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rspv[0]), 32'd1);
      chk("t1_read_zero", 32'(dout[0]), 32'd0);
      step();
    end

    // vector table, one transaction at a time
    for (int i = 0; i < 9; i++) begin
      req(0, vt[i].w, vt[i].a, vt[i].d);
      @(negedge clk);
      chk("vec_rsp_valid", 32'(rspv[0]), 32'd1);
      chk("vec_data", 32'(dout[0]), 32'(vt[i].exp_d));
      chk("vec_debug", 32'(dbg[0]), 32'(vt[i].exp_dbg));
      step();
    end

    // 2: write then read of the same address on the next cycle
    rv[0] = 1'b1; we_s[0] = 1'b1; addr[0] = 3'd2; din[0] = 8'hA5;
    step();
    we_s[0] = 1'b0;
    @(negedge clk);
    chk("t2_write_rsp_old", 32'(dout[0]), 32'h00);
    step();
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t2_read_new", 32'(dout[0]), 32'hA5);
    chk("t2_debug_read", 32'(dbg[0]), 32'd2);
    step();

    // 3: write-first, latency 2, three back-to-back requests
    do_reset(1);
    wait_ready(1);
    rv[1] = 1'b1; we_s[1] = 1'b1; addr[1] = 3'd5; din[1] = 8'h3C;
    step();
    we_s[1] = 1'b0; addr[1] = 3'd5;
    @(negedge clk);
    chk("t3_no_rsp_yet", 32'(rspv[1]), 32'd0);
    step();
    addr[1] = 3'd4;
    @(negedge clk);
    chk("t3_rsp0_valid", 32'(rspv[1]), 32'd1);
    chk("t3_rsp0_data", 32'(dout[1]), 32'h3C);
    step();
    rv[1] = 1'b0;
    @(negedge clk);
    chk("t3_rsp1_valid", 32'(rspv[1]), 32'd1);
    chk("t3_rsp1_data", 32'(dout[1]), 32'h3C);
    step();
    @(negedge clk);
    chk("t3_rsp2_valid", 32'(rspv[1]), 32'd1);
    chk("t3_rsp2_data", 32'(dout[1]), 32'h00);
    step();
    @(negedge clk);
    chk("t3_rsp_done", 32'(rspv[1]), 32'd0);
    step();

    // 4: fill, clear with a read in flight, second clear mid-sweep
    do_reset(0);
    wait_ready(0);
    for (int i = 0; i < N; i++) req(0, 1'b1, i, i + 1);
    rv[0] = 1'b1; we_s[0] = 1'b0; addr[0] = 3'd7;
    step();
    rv[0] = 1'b0; clr[0] = 1'b1;
    @(negedge clk);
    chk("t4_inflight_valid", 32'(rspv[0]), 32'd1);
    chk("t4_inflight_data", 32'(dout[0]), 32'h08);
    chk("t4_clear_blocks", 32'(rdy[0]), 32'd0);
    step();
    clr[0] = 1'b0;
    repeat (3) step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    count_busy(0, n);
    chk("t4_sweep_not_extended", 32'(n), 32'd4);
    for (int i = 0; i < N; i++) begin
      req(0, 1'b0, i, 0);
      @(negedge clk);
      chk("t4_read_zero", 32'(dout[0]), 32'd0);
      step();
    end

    // 5: reset in the middle of a sweep
    req(0, 1'b1, 2, 'h77);
    req(0, 1'b0, 2, 0);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", 32'(rspv[0]), 32'd0);
    chk("t5_data_out", 32'(dout[0]), 32'd0);
    chk("t5_debug", 32'(dbg[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy(0, n);
    chk("t5_full_sweep", 32'(n), 32'd8);

    // 6: no clear on reset, eight back-to-back writes
    do_reset(2);
    @(negedge clk);
    chk("t6_ready_now", 32'(rdy[2]), 32'd1);
    chk("t6_not_busy", 32'(busy_s[2]), 32'd0);
    step();
    base = rsp2_cnt;
    for (int i = 0; i < N; i++) req(2, 1'b1, i, 'h10 + i);
    repeat (4) step();
    chk("t6_rsp_count", 32'(rsp2_cnt - base), 32'd8);

    // randomized traffic on each configuration
    random_run(2, 300);
    do_reset(1);
    random_run(1, 400);
    do_reset(0);
    random_run(0, 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
